matrix_scan_ctrl: RTL and testbench

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/matrix_disp_timer.sv | 65 ++++++
 rtl/matrix_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// ------------------------------------------------------------------
// matrix_pkg : shared types, widths and frame-buffer address layout
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package matrix_pkg;

   localparam int ROW_W  = 4;
   localparam int COL_W  = 6;
   localparam int RGB_W  = 6;
   localparam int ADDR_W = 1 + ROW_W + COL_W;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREFETCH = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_LATCH    = 3'd3,
      ST_DISPLAY  = 3'd4
   } state_t;

   // Frame-buffer address: {buf_sel, row, col}
   function automatic logic [ADDR_W-1:0] make_addr(
      input logic             buf_sel,
      input logic [ROW_W-1:0] row,
      input logic [COL_W-1:0] col
   );
      return {buf_sel, row, col};
   endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_disp_timer.sv
// ------------------------------------------------------------------
// matrix_disp_timer : DISPLAY-phase down-counter with brightness OE gating
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module matrix_disp_timer #(
   parameter int DISP_CYCLES = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] brightness,
   output logic       done,
   output logic       oe
);

   localparam int CNT_W = $clog2(DISP_CYCLES);
   localparam int STEP  = DISP_CYCLES / 8;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] on_floor;
   logic [CNT_W-1:0] on_floor_nxt;
   logic             active;
   logic             active_nxt;

   // Panel stays lit while the count is at or above on_floor, so the
   // lit window sits at the start of DISPLAY.
   always_comb begin
      cnt_nxt      = cnt;
      active_nxt   = active;
      on_floor_nxt = on_floor;
      if (start) begin
         cnt_nxt      = CNT_W'(DISP_CYCLES - 1);
         active_nxt   = 1'b1;
         on_floor_nxt = CNT_W'(DISP_CYCLES - (int'(brightness) + 1) * STEP);
      end else if (active) begin
         if (cnt == '0) begin
            active_nxt = 1'b0;
         end else begin
            cnt_nxt = cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt      <= '0;
         on_floor <= '0;
         active   <= 1'b0;
         oe       <= 1'b1;
      end else begin
         cnt      <= cnt_nxt;
         on_floor <= on_floor_nxt;
         active   <= active_nxt;
         oe       <= !(active_nxt && (cnt_nxt >= on_floor_nxt));
      end
   end

   assign done = active && (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
// ------------------------------------------------------------------
// matrix_scan_ctrl : 1/16-scan RGB LED matrix row scanner, double-buffered;
// optional brightness input when MATRIX_BRIGHTNESS_EN is defined.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int COLS        = 64,
   parameter int DISP_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              swap_req,
`ifdef MATRIX_BRIGHTNESS_EN
   input  logic [2:0]        brightness,
`endif
   output logic              swap_ack,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [RGB_W-1:0]  rd_data,
   output logic              A,
   output logic              B,
   output logic              C,
   output logic              D,
   output logic              R0,
   output logic              G0,
   output logic              B0,
   output logic              R1,
   output logic              G1,
   output logic              B1,
   output logic              SCLK,
   output logic              OE,
   output logic              LAT,
   output logic              frame_start
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] row_nxt;
   logic [CW-1:0]    col;
   logic [CW-1:0]    col_nxt;
   logic             phase;
   logic             phase_nxt;
   logic             buf_sel;
   logic             buf_nxt;
   logic             flip;
   logic             disp_start;
   logic             disp_done;
   logic [RGB_W-1:0] rgb;
   logic [ROW_W-1:0] scan_row;
   logic [2:0]       bright;

`ifdef MATRIX_BRIGHTNESS_EN
   assign bright = brightness;
`else
   assign bright = 3'd7;
`endif

   always_comb begin
      state_nxt  = state;
      row_nxt    = row;
      col_nxt    = col;
      phase_nxt  = phase;
      buf_nxt    = buf_sel;
      flip       = 1'b0;
      disp_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) state_nxt = ST_PREFETCH;
         end
         ST_PREFETCH: begin
            state_nxt = ST_SHIFT;
            phase_nxt = 1'b0;
            col_nxt   = '0;
         end
         ST_SHIFT: begin
            if (!phase) begin
               phase_nxt = 1'b1;
               col_nxt   = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
            end else begin
               phase_nxt = 1'b0;
               // col has already wrapped back to 0 after the last column
               if (col == '0) state_nxt = ST_LATCH;
            end
         end
         ST_LATCH: begin
            state_nxt  = ST_DISPLAY;
            disp_start = 1'b1;
         end
         ST_DISPLAY: begin
            if (disp_done) begin
               row_nxt   = row + ROW_W'(1);
               state_nxt = enable ? ST_PREFETCH : ST_IDLE;
               if ((row == '1) && swap_req) begin
                  buf_nxt = !buf_sel;
                  flip    = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         row         <= '0;
         col         <= '0;
         phase       <= 1'b0;
         buf_sel     <= 1'b0;
         rgb         <= '0;
         scan_row    <= '0;
         SCLK        <= 1'b0;
         LAT         <= 1'b0;
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         row         <= row_nxt;
         col         <= col_nxt;
         phase       <= phase_nxt;
         buf_sel     <= buf_nxt;
         if ((state == ST_SHIFT) && !phase) rgb <= rd_data;
         if (state_nxt == ST_LATCH) scan_row <= row;
         SCLK        <= (state_nxt == ST_SHIFT) && phase_nxt;
         LAT         <= (state_nxt == ST_LATCH);
         swap_ack    <= flip;
         frame_start <= (state_nxt == ST_PREFETCH) && (row_nxt == '0);
      end
   end

   matrix_disp_timer #(
      .DISP_CYCLES (DISP_CYCLES)
   ) u_disp_timer (
      .clk        (clk),
      .rst        (rst),
      .start      (disp_start),
      .brightness (bright),
      .done       (disp_done),
      .oe         (OE)
   );

   assign rd_addr            = make_addr(buf_sel, row, COL_W'(col));
   assign {D, C, B, A}       = scan_row;
   assign {R0, G0, B0, R1, G1, B1} = rgb;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
// ------------------------------------------------------------------
// tb_matrix_scan_ctrl : directed self-checking bench for matrix_scan_ctrl
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_matrix_scan_ctrl;

   localparam int COLS      = 64;
   localparam int DISP      = 256;
   localparam int ROW_CYC   = 1 + 2 * COLS + 1 + DISP;
   localparam int FRAME_CYC = 16 * ROW_CYC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        swap_req = 1'b0;
   logic        swap_ack;
   logic [10:0] rd_addr;
   logic [5:0]  rd_data;
   logic        A, B, C, D, R0, G0, B0, R1, G1, B1;
   logic        SCLK, OE, LAT, frame_start;
`ifdef MATRIX_BRIGHTNESS_EN
   logic [2:0]  brightness = 3'd7;
`endif

   logic [5:0]  rgb;
   logic [3:0]  scan_row;
   assign rgb      = {R0, G0, B0, R1, G1, B1};
   assign scan_row = {D, C, B, A};

   int checks   = 0;
   int failures = 0;

   logic [5:0] mem [0:2047];

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   matrix_scan_ctrl #(
      .COLS        (COLS),
      .DISP_CYCLES (DISP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .swap_req    (swap_req),
`ifdef MATRIX_BRIGHTNESS_EN
      .brightness  (brightness),
`endif
      .swap_ack    (swap_ack),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .A           (A),
      .B           (B),
      .C           (C),
      .D           (D),
      .R0          (R0),
      .G0          (G0),
      .B0          (B0),
      .R1          (R1),
      .G1          (G1),
      .B1          (B1),
      .SCLK        (SCLK),
      .OE          (OE),
      .LAT         (LAT),
      .frame_start (frame_start)
   );

   function automatic logic [5:0] pat(input int b, input int r, input int c);
      int v;
      v = c + 3 * r + 17 * b;
      return v[5:0];
   endfunction

   task automatic do_reset();
      rst = 1'b0; enable = 1'b0; swap_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b1; swap_req = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({OE, LAT, SCLK} !== 3'b100) begin
         failures++; $display("FAIL reset_ctrl: {OE,LAT,SCLK}=%b expected 100", {OE, LAT, SCLK});
      end
      checks++;
      if (rgb !== 6'd0) begin
         failures++; $display("FAIL reset_rgb: got %h expected 00", rgb);
      end
      checks++;
      if (rd_addr !== 11'd0) begin
         failures++; $display("FAIL reset_addr: got %h expected 000", rd_addr);
      end
      checks++;
      if ({swap_ack, frame_start} !== 2'b00) begin
         failures++; $display("FAIL reset_pulses: got %b expected 00", {swap_ack, frame_start});
      end
      checks++;
      if (scan_row !== 4'd0) begin
         failures++; $display("FAIL reset_row: got %0d expected 0", scan_row);
      end
      enable = 1'b0; swap_req = 1'b0; rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({OE, SCLK, frame_start} !== 3'b100 || rd_addr !== 11'd0) begin
         failures++;
         $display("FAIL idle_hold: OE/SCLK/fs=%b addr=%h expected 100 000", {OE, SCLK, frame_start}, rd_addr);
      end
   endtask

   task automatic test_row_timing();
      int  fs_cyc = -1, lat_cyc = -1, oe_low = 0, rises = 0, fs_cnt = 0, lat_row = -1;
      logic prev = 1'b0;
      enable = 1'b1;
      for (int k = 1; k <= ROW_CYC; k++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_cyc < 0) fs_cyc = k;
         end
         if (LAT === 1'b1 && lat_cyc < 0) begin
            lat_cyc = k; lat_row = int'(scan_row);
         end
         if (OE === 1'b0) oe_low++;
         if (SCLK === 1'b1 && prev === 1'b0) rises++;
         prev = SCLK;
      end
      checks++;
      if (fs_cyc != 1 || fs_cnt != 1) begin
         failures++; $display("FAIL frame_start_cycle: got cycle %0d count %0d expected 1 1", fs_cyc, fs_cnt);
      end
      checks++;
      if (lat_cyc != 130) begin
         failures++; $display("FAIL first_lat_cycle: got %0d expected 130", lat_cyc);
      end
      checks++;
      if (lat_row != 0) begin
         failures++; $display("FAIL first_lat_row: got %0d expected 0", lat_row);
      end
      checks++;
      if (oe_low != 256) begin
         failures++; $display("FAIL oe_low_cycles: got %0d expected 256", oe_low);
      end
      checks++;
      if (rises != COLS) begin
         failures++; $display("FAIL sclk_rises: got %0d expected %0d", rises, COLS);
      end
      @(negedge clk);
      checks++;
      if (frame_start !== 1'b0 || OE !== 1'b1 || rd_addr !== {1'b0, 4'd1, 6'd0}) begin
         failures++;
         $display("FAIL row1_prefetch: fs=%b OE=%b addr=%h expected 0 1 040", frame_start, OE, rd_addr);
      end
   endtask

   // Runs from a frame_start cycle to the next one, checking every pixel.
   task automatic run_frame(input logic exp_buf, input int sw_on, input int sw_off,
                            output int acks, output logic end_buf);
      int   row = 0, col = 0, k = 0;
      logic prev = 1'b0;
      bit   done = 1'b0;
      acks = 0; end_buf = exp_buf;
      checks++;
      if (rd_addr[10] !== exp_buf) begin
         failures++; $display("FAIL frame_buf: got %b expected %b", rd_addr[10], exp_buf);
      end
      while (!done && k < FRAME_CYC + 50) begin
         swap_req = (k >= sw_on) && (k < sw_off);
         @(negedge clk);
         k++;
         if (swap_ack === 1'b1) acks++;
         if (SCLK === 1'b1 && prev === 1'b0) begin
            checks++;
            if (rgb !== pat(int'(exp_buf), row, col)) begin
               failures++;
               $display("FAIL pixel b%0d r%0d c%0d: got %h expected %h", exp_buf, row, col, rgb,
                        pat(int'(exp_buf), row, col));
            end
            col++;
         end
         prev = SCLK;
         if (LAT === 1'b1) begin
            checks++;
            if (int'(scan_row) != row || col != COLS) begin
               failures++;
               $display("FAIL lat_row: row %0d cols %0d expected row %0d cols %0d", scan_row, col, row, COLS);
            end
            row++; col = 0;
         end
         if (frame_start === 1'b1) begin
            done = 1'b1; end_buf = rd_addr[10];
         end
      end
      checks++;
      if (!done || k != FRAME_CYC || row != 16) begin
         failures++; $display("FAIL frame_len: cycles %0d rows %0d expected %0d 16", k, row, FRAME_CYC);
      end
   endtask

   task automatic test_data();
      int   acks, n = 0;
      logic b;
      do_reset();
      enable = 1'b1;
      while (frame_start !== 1'b1 && n < 10) begin
         @(negedge clk); n++;
      end
      run_frame(1'b0, -1, -1, acks, b);
      checks++;
      if (acks != 0 || b !== 1'b0) begin
         failures++; $display("FAIL no_req_swap: acks %0d buf %b expected 0 0", acks, b);
      end
   endtask

   task automatic test_swap_pulse();
      int   acks;
      logic b;
      run_frame(1'b0, 3000, 3010, acks, b);
      checks++;
      if (acks != 0 || b !== 1'b0) begin
         failures++; $display("FAIL short_swap_req: acks %0d buf %b expected 0 0", acks, b);
      end
   endtask

   task automatic test_swap_hold();
      int   acks;
      logic b;
      run_frame(1'b0, 5000, 1 << 30, acks, b);
      checks++;
      if (acks != 1 || b !== 1'b1) begin
         failures++; $display("FAIL swap_first: acks %0d buf %b expected 1 1", acks, b);
      end
      run_frame(1'b1, 0, 1 << 30, acks, b);
      checks++;
      if (acks != 1 || b !== 1'b0) begin
         failures++; $display("FAIL swap_second: acks %0d buf %b expected 1 0", acks, b);
      end
      run_frame(1'b0, 0, 1 << 30, acks, b);
      checks++;
      if (acks != 1 || b !== 1'b1) begin
         failures++; $display("FAIL swap_third: acks %0d buf %b expected 1 1", acks, b);
      end
      swap_req = 1'b0;
   endtask

   task automatic test_reset_mid_display();
      int lats = 0, n = 0;
      swap_req = 1'b0;
      while (lats < 2 && n < 2000) begin
         @(negedge clk); n++;
         if (LAT === 1'b1) lats++;
      end
      repeat (20) @(negedge clk);
      checks++;
      if (OE !== 1'b0 || rd_addr !== {1'b1, 4'd1, 6'd0}) begin
         failures++; $display("FAIL pre_reset_display: OE=%b addr=%h expected 0 440", OE, rd_addr);
      end
      rst = 1'b0; enable = 1'b0;
      @(negedge clk);
      checks++;
      if (OE !== 1'b1 || rd_addr !== 11'd0 || scan_row !== 4'd0) begin
         failures++;
         $display("FAIL mid_reset_state: OE=%b addr=%h row=%0d expected 1 000 0", OE, rd_addr, scan_row);
      end
      checks++;
      if ({LAT, SCLK, swap_ack, frame_start} !== 4'b0000 || rgb !== 6'd0) begin
         failures++;
         $display("FAIL mid_reset_outs: lat/sclk/ack/fs=%b rgb=%h expected 0000 00",
                  {LAT, SCLK, swap_ack, frame_start}, rgb);
      end
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({OE, SCLK, frame_start} !== 3'b100) begin
         failures++; $display("FAIL post_reset_idle: OE/SCLK/fs=%b expected 100", {OE, SCLK, frame_start});
      end
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if (frame_start !== 1'b1 || rd_addr !== 11'd0) begin
         failures++; $display("FAIL post_reset_start: fs=%b addr=%h expected 1 000", frame_start, rd_addr);
      end
   endtask

   task automatic test_enable_drop();
      int   lats = 0, n = 0, oe_low = 0, rises_after = 0, lat_row = -1, fs = 0;
      logic prev;
      bit   seen_lat = 1'b0;
      do_reset();
      enable = 1'b1;
      while (lats < 5 && n < 3000) begin
         @(negedge clk); n++;
         if (LAT === 1'b1) lats++;
      end
      while (SCLK !== 1'b1 && n < 3000) begin
         @(negedge clk); n++;
      end
      enable = 1'b0;
      prev = SCLK;
      for (int j = 0; j < 600; j++) begin
         @(negedge clk);
         if (LAT === 1'b1) begin
            seen_lat = 1'b1; lat_row = int'(scan_row);
         end
         if (OE === 1'b0) oe_low++;
         if (seen_lat && SCLK === 1'b1 && prev === 1'b0) rises_after++;
         prev = SCLK;
      end
      checks++;
      if (lats != 5 || lat_row != 5) begin
         failures++; $display("FAIL drop_lat_row: lats %0d row %0d expected 5 5", lats, lat_row);
      end
      checks++;
      if (oe_low != 256) begin
         failures++; $display("FAIL drop_display_len: got %0d expected 256", oe_low);
      end
      checks++;
      if (rises_after != 0 || OE !== 1'b1 || rd_addr !== {1'b0, 4'd6, 6'd0}) begin
         failures++;
         $display("FAIL drop_idle: rises %0d OE=%b addr=%h expected 0 1 180", rises_after, OE, rd_addr);
      end
      enable = 1'b1;
      lat_row = -1; n = 0;
      while (lat_row < 0 && n < 500) begin
         @(negedge clk); n++;
         if (frame_start === 1'b1) fs++;
         if (LAT === 1'b1) lat_row = int'(scan_row);
      end
      checks++;
      if (lat_row != 6 || fs != 0) begin
         failures++; $display("FAIL resume_row: row %0d frame_starts %0d expected 6 0", lat_row, fs);
      end
   endtask

`ifdef MATRIX_BRIGHTNESS_EN
   task automatic test_brightness();
      int n = 0, low = 0, high = 0;
      bit got = 1'b0;
      do_reset();
      brightness = 3'd3;
      enable = 1'b1;
      while (!got && n < 400) begin
         @(negedge clk); n++;
         if (LAT === 1'b1) got = 1'b1;
      end
      for (int j = 1; j <= DISP; j++) begin
         @(negedge clk);
         if (j <= 128 && OE === 1'b0) low++;
         if (j > 128 && OE === 1'b1) high++;
         if (j == 1) brightness = 3'd0;
      end
      checks++;
      if (low != 128 || high != 128) begin
         failures++; $display("FAIL bright3: lit %0d blank %0d expected 128 128", low, high);
      end
      got = 1'b0; n = 0; low = 0; high = 0;
      while (!got && n < 400) begin
         @(negedge clk); n++;
         if (LAT === 1'b1) got = 1'b1;
      end
      for (int j = 1; j <= DISP; j++) begin
         @(negedge clk);
         if (j <= 32 && OE === 1'b0) low++;
         if (j > 32 && OE === 1'b1) high++;
      end
      checks++;
      if (low != 32 || high != 224) begin
         failures++; $display("FAIL bright0: lit %0d blank %0d expected 32 224", low, high);
      end
      brightness = 3'd7;
   endtask
`endif

   initial begin
      for (int a = 0; a < 2048; a++) mem[a] = pat(a / 1024, (a / 64) % 16, a % 64);
      test_reset();
      test_row_timing();
      test_data();
      test_swap_pulse();
      test_swap_hold();
      test_reset_mid_display();
      test_enable_drop();
`ifdef MATRIX_BRIGHTNESS_EN
      test_brightness();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
